// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter: issues one strobed command at a time to a
// peripheral and returns read data, aborting reads whose ready flag never arrives.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        o_bus_stb,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_data,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_data_ready,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic        ptr;
    logic        owner;
    logic [7:0]  wait_cnt;

    logic        pick_m1;
    logic        finish;
    logic        load_rdata;
    logic        timeout_hit;
    logic [31:0] rdata_value;

    // The pointer only matters when both requesters compete.
    assign pick_m1 = m1_req & (~m0_req | ptr);

    always_comb begin
        finish      = 1'b0;
        load_rdata  = 1'b0;
        timeout_hit = 1'b0;
        rdata_value = i_bus_data;
        case (state)
            ISSUE: begin
                if (o_bus_we) begin
                    finish = 1'b1;
                end else if (i_bus_data_ready) begin
                    finish     = 1'b1;
                    load_rdata = 1'b1;
                end
            end
            WAIT: begin
                // Ready is checked first so a late ready still returns real data.
                if (i_bus_data_ready) begin
                    finish     = 1'b1;
                    load_rdata = 1'b1;
                end else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                    finish      = 1'b1;
                    load_rdata  = 1'b1;
                    timeout_hit = 1'b1;
                    rdata_value = 32'hFFFF_FFFF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            wait_cnt   <= 8'd0;
            m0_rdata   <= 32'd0;
            m0_ack     <= 1'b0;
            m1_rdata   <= 32'd0;
            m1_ack     <= 1'b0;
            o_bus_stb  <= 1'b0;
            o_bus_we   <= 1'b0;
            o_bus_addr <= 32'd0;
            o_bus_data <= 32'd0;
            o_grant    <= 2'b00;
            o_timeout  <= 1'b0;
        end else begin
            o_bus_stb <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= pick_m1;
                        o_bus_we   <= pick_m1 ? m1_we    : m0_we;
                        o_bus_addr <= pick_m1 ? m1_addr  : m0_addr;
                        o_bus_data <= pick_m1 ? m1_wdata : m0_wdata;
                        o_grant    <= pick_m1 ? 2'b10 : 2'b01;
                        o_bus_stb  <= 1'b1;
                        wait_cnt   <= 8'd0;
                        state      <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (finish) begin
                        state     <= DONE;
                        m0_ack    <= ~owner;
                        m1_ack    <= owner;
                        o_timeout <= timeout_hit;
                        if (load_rdata) begin
                            if (owner) m1_rdata <= rdata_value;
                            else       m0_rdata <= rdata_value;
                        end
                    end else if (state == ISSUE) begin
                        state <= WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    o_grant <= 2'b00;
                    ptr     <= ~owner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of cycles a read waits for ready before abort; legal range 1..255.
REQ-002 clk_i  in  1  pixel-domain system clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 m0_req / m1_req  in  1  requester 0/1 transaction request, level, held until ack.
REQ-005 m0_we / m1_we  in  1  1 = write, 0 = read; valid while req high.
REQ-006 m0_addr / m1_addr  in  32  transaction address.
REQ-007 m0_wdata / m1_wdata  in  32  write data.
REQ-008 m0_rdata / m1_rdata  out  32  read data, valid in ack cycle.
REQ-009 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-010 o_bus_stb  out  1  one-cycle bus strobe to peripheral.
REQ-011 o_bus_we / o_bus_addr / o_bus_data  out  1/32/32  latched command of granted requester.
REQ-012 i_bus_data  in  32  peripheral read data.
REQ-013 i_bus_data_ready  in  1  peripheral read-complete flag.
REQ-014 o_grant  out  2  one-hot owner of the current transaction, 00 when idle.
REQ-015 o_timeout  out  1  one-cycle pulse when a read is aborted.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-017 IDLE: with any req high, select winner, latch its we/addr/wdata into o_bus_*, set o_grant, go ISSUE; else stay IDLE.
REQ-018 Arbitration round-robin: priority pointer selects the preferred requester; after each completed or aborted transaction it points to the other requester.
REQ-019 Both req high in same IDLE cycle: pointer's requester wins; other waits, no request dropped.
REQ-020 ISSUE: o_bus_stb = 1 for exactly this one cycle; write -> DONE; read -> WAIT if i_bus_data_ready low, else capture i_bus_data and go DONE.
REQ-021 WAIT: o_bus_stb = 0; on i_bus_data_ready = 1 capture i_bus_data, go DONE.
REQ-022 Timeout counter (8 bits) clears on ISSUE entry, increments each WAIT cycle; on reaching TIMEOUT_CYCLES without ready, capture 32'hFFFF_FFFF, pulse o_timeout with the DONE cycle, go DONE.
REQ-023 Ready and timeout in same cycle: ready wins, real data returned, no o_timeout.
REQ-024 DONE: winner's ack = 1 and its rdata = captured data (writes: rdata holds previous value); o_grant cleared on exit; advance pointer; go IDLE.
REQ-025 Latency: req sampled high in IDLE cycle N -> o_bus_stb high cycle N+1; write ack cycle N+2; read ack cycle after ready sampled (min N+2).
REQ-026 i_bus_data_ready is ignored in IDLE and DONE.
REQ-027 Requester SHALL drop req in the cycle after ack; req still high in the following IDLE is a new transaction.
REQ-028 Non-granted requester's ack stays 0 and its rdata unchanged throughout.
REQ-029 Changes of m*_addr/wdata/we after grant do not affect the in-flight transaction.

Reset
REQ-030 rstn_i low SHALL immediately force state IDLE, pointer to requester 0, counter 0, and all outputs (acks, rdata, o_bus_*, o_grant, o_timeout) to 0, including mid-transaction; the interrupted transaction is never acked.
REQ-031 First arbitration decision occurs on the first rising edge with rstn_i high.

Verification
REQ-032 m0 write addr 0x10 data 0xA5, ready never asserted -> stb cycle N+1 with we=1 addr 0x10 data 0xA5, m0_ack cycle N+2, o_grant 01 during N+1..N+2.
REQ-033 m1 read addr 0x05, ready asserted 3 cycles after stb with i_bus_data 0x42 -> m1_ack one cycle later, m1_rdata 0x42, m0_ack stays 0.
REQ-034 m0 and m1 both req continuously after reset -> grants alternate m0, m1, m0, m1; no starvation.
REQ-035 m0 read with ready never asserted, TIMEOUT_CYCLES=4 -> m0_ack and o_timeout together after 4 WAIT cycles, m0_rdata 0xFFFF_FFFF, next grant goes to m1.
REQ-036 rstn_i pulsed low during WAIT -> all outputs 0 at once, no ack; after release, pending m1 req served before m0 only if m0 not requesting (pointer back at m0).
